// File: rtl/ssr_pkg.sv
// ssr_pkg: shared types and default sizes for the speech-recognition sequencer.
//   ssr_state_t : sequencer states (IDLE, CAPTURE, INFER_START, INFER_WAIT)
//   N_FEAT, FEAT_W, CLASS_W : default feature-vector and class dimensions
//   feat_vec_t  : one feature vector as an array of signed elements
package ssr_pkg;

    localparam int N_FEAT  = 26;
    localparam int FEAT_W  = 8;
    localparam int CLASS_W = 2;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CAPTURE     = 2'd1,
        INFER_START = 2'd2,
        INFER_WAIT  = 2'd3
    } ssr_state_t;

    typedef logic signed [FEAT_W-1:0] feat_vec_t [N_FEAT];

endpackage

// File: rtl/ssr_debounce.sv
// ssr_debounce: button conditioning for the sequencer.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   but   in  raw asynchronous push-button
//   press out one-cycle pulse on a rising edge of the debounced level
// The button is brought into the clock domain with two flops. The debounced
// level only follows the synchronised input after DEB_CYCLES consecutive
// samples that differ from the current level.
module ssr_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic but,
    output logic press
);
    import ssr_pkg::*;

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_prev_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg      <= 1'b0;
            sync2_reg      <= 1'b0;
            level_reg      <= 1'b0;
            level_prev_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            sync1_reg      <= but;
            sync2_reg      <= sync1_reg;
            level_prev_reg <= level_reg;
            // The counter tracks how long the input has disagreed with the
            // accepted level; any agreeing sample restarts the run.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Both terms are registers, so the pulse is glitch-free and lasts one cycle.
    assign press = level_reg & ~level_prev_reg;

endmodule

// File: rtl/ssr_ctrl.sv
// ssr_ctrl: capture -> infer -> report sequencer for the recognition path.
//   clk, rst     clock and synchronous active-high reset
//   but          raw push-button, debounced into a one-cycle press
//   feat_start   pulse requesting a feature capture (first CAPTURE cycle)
//   feat_valid   feat_vec valid this cycle (accepted only in CAPTURE)
//   feat_vec     flattened feature vector, element i at [i*FEAT_W +: FEAT_W]
//   nn_vec       registered snapshot of feat_vec driven to the NN core
//   nn_start     pulse starting inference (INFER_START)
//   nn_done      nn_class valid this cycle (accepted only in INFER_WAIT)
//   nn_class     NN result
//   class_out    latched result; class_valid marks it as current
//   busy         registered, high whenever the state is not IDLE
//   error        last cycle aborted by the watchdog
// Optional feature: define SSR_CTRL_WDOG_EN to enable a per-wait-state
// watchdog of TIMEOUT_CYCLES; without it the FSM waits indefinitely and
// error stays 0.
module ssr_ctrl #(
    parameter int N_FEAT         = 26,
    parameter int FEAT_W         = 8,
    parameter int CLASS_W        = 2,
    parameter int DEB_CYCLES     = 1_000_000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              but,
    output logic                              feat_start,
    input  logic                              feat_valid,
    input  logic signed [N_FEAT*FEAT_W-1:0]   feat_vec,
    output logic signed [N_FEAT*FEAT_W-1:0]   nn_vec,
    output logic                              nn_start,
    input  logic                              nn_done,
    input  logic        [CLASS_W-1:0]         nn_class,
    output logic        [CLASS_W-1:0]         class_out,
    output logic                              class_valid,
    output logic                              busy,
    output logic                              error
);
    import ssr_pkg::*;

    logic               press;
    ssr_state_t         state_reg;
    logic               feat_start_reg;
    logic               nn_start_reg;
    logic               busy_reg;
    logic [CLASS_W-1:0] class_reg;
    logic               class_valid_reg;
    logic               error_reg;
    logic               snap_en;
    logic               wd_expired;

    ssr_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .but   (but),
        .press (press)
    );

    // Snapshot register: one element per generate slice.
    assign snap_en = (state_reg == CAPTURE) && feat_valid;

    for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_snap
        logic signed [FEAT_W-1:0] elem_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                elem_reg <= '0;
            end else if (snap_en) begin
                elem_reg <= feat_vec[gi*FEAT_W +: FEAT_W];
            end
        end
        assign nn_vec[gi*FEAT_W +: FEAT_W] = elem_reg;
    end

`ifdef SSR_CTRL_WDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_reg;

    // Held at zero in the states that precede each wait state, so it is
    // cleared on entry and counts the cycles spent in CAPTURE / INFER_WAIT.
    always_ff @(posedge clk) begin
        if (rst || state_reg == IDLE || state_reg == INFER_START) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end

    assign wd_expired = (wd_cnt_reg == WD_LAST);
`else
    // Watchdog absent: the timeout parameter is intentionally left idle.
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            feat_start_reg  <= 1'b0;
            nn_start_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            class_reg       <= '0;
            class_valid_reg <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            feat_start_reg <= 1'b0;
            nn_start_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (press) begin
                        state_reg       <= CAPTURE;
                        feat_start_reg  <= 1'b1;
                        busy_reg        <= 1'b1;
                        class_valid_reg <= 1'b0;
                        error_reg       <= 1'b0;
                    end
                end
                CAPTURE: begin
                    // The awaited pulse takes priority over a same-cycle expiry.
                    if (feat_valid) begin
                        state_reg    <= INFER_START;
                        nn_start_reg <= 1'b1;
                    end else if (wd_expired) begin
                        state_reg       <= IDLE;
                        busy_reg        <= 1'b0;
                        class_valid_reg <= 1'b0;
                        error_reg       <= 1'b1;
                    end
                end
                INFER_START: begin
                    state_reg <= INFER_WAIT;
                end
                INFER_WAIT: begin
                    if (nn_done) begin
                        state_reg       <= IDLE;
                        busy_reg        <= 1'b0;
                        class_reg       <= nn_class;
                        class_valid_reg <= 1'b1;
                    end else if (wd_expired) begin
                        state_reg       <= IDLE;
                        busy_reg        <= 1'b0;
                        class_valid_reg <= 1'b0;
                        error_reg       <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign feat_start  = feat_start_reg;
    assign nn_start    = nn_start_reg;
    assign busy        = busy_reg;
    assign class_out   = class_reg;
    assign class_valid = class_valid_reg;
    assign error       = error_reg;

endmodule

// File: tb/tb_ssr_ctrl.sv
// Testbench for ssr_ctrl with DEB_CYCLES=4 and TIMEOUT_CYCLES=16.
// The reference model holds the expected snapshot, result and flags as
// plain variables updated from the sequencing rules as stimulus is applied.
module tb_ssr_ctrl;
    localparam int N_FEAT  = 26;
    localparam int FEAT_W  = 8;
    localparam int CLASS_W = 2;
    localparam int DEB     = 4;
    localparam int TMO     = 16;

    logic clk = 1'b0;
    logic rst, but, feat_valid, nn_done;
    logic signed [N_FEAT*FEAT_W-1:0] feat_vec, nn_vec;
    logic [CLASS_W-1:0] nn_class, class_out;
    logic feat_start, nn_start, class_valid, busy, error;

    int total = 0;
    int bad   = 0;

    // reference model
    int exp_vec [N_FEAT];
    int exp_class;
    int exp_valid;
    int stim_vec [N_FEAT];

    always #5 clk = ~clk;

    ssr_ctrl #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
        .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .but(but),
        .feat_start(feat_start), .feat_valid(feat_valid), .feat_vec(feat_vec),
        .nn_vec(nn_vec), .nn_start(nn_start), .nn_done(nn_done),
        .nn_class(nn_class), .class_out(class_out), .class_valid(class_valid),
        .busy(busy), .error(error)
    );

    // One cycle: inputs set before the call are sampled at this edge;
    // outputs are read 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic random_stim();
        for (int i = 0; i < N_FEAT; i++) stim_vec[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic drive_stim();
        logic [31:0] tmp;
        for (int i = 0; i < N_FEAT; i++) begin
            tmp = stim_vec[i];
            feat_vec[i*FEAT_W +: FEAT_W] = tmp[FEAT_W-1:0];
        end
    endtask

    // Index of the first nn_vec element differing from the model, or -1.
    function automatic int vec_diff();
        for (int i = 0; i < N_FEAT; i++)
            if (int'($signed(nn_vec[i*FEAT_W +: FEAT_W])) != exp_vec[i]) return i;
        return -1;
    endfunction

    task automatic release_but();
        but = 1'b0;
        repeat (10) tick();
    endtask

    // Raise the button and count cycles until feat_start (-1 on timeout).
    task automatic press_and_wait(output int lat);
        but = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (feat_start) begin
                lat = n;
                break;
            end
        end
    endtask

    // Starting in the feat_start cycle: finish one recognition cycle with
    // ignored nn_done noise before capture and feat_valid noise afterwards.
    task automatic finish_cycle(input int fv_delay, input int nd_delay, input int cls, input string tag);
        int d;
        repeat (fv_delay) begin
            nn_done = 1'($urandom_range(0, 1));
            nn_class = CLASS_W'($urandom_range(0, 3));
            tick();
            nn_done = 1'b0;
        end
        random_stim();
        drive_stim();
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        for (int i = 0; i < N_FEAT; i++) exp_vec[i] = stim_vec[i];
        total++;
        if (nn_start !== 1'b1 || busy !== 1'b1)
            begin bad++; $display("FAIL %s nn_start: got start=%b busy=%b want 1/1", tag, nn_start, busy); end
        d = vec_diff();
        total++;
        if (d >= 0)
            begin bad++; $display("FAIL %s snapshot: elem %0d got %0d want %0d", tag, d, $signed(nn_vec[d*FEAT_W +: FEAT_W]), exp_vec[d]); end
        tick();
        total++;
        if (nn_start !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL %s infer_wait: got start=%b busy=%b want 0/1", tag, nn_start, busy); end
        repeat (nd_delay) begin
            random_stim();
            drive_stim();
            feat_valid = 1'b1;
            tick();
            feat_valid = 1'b0;
        end
        nn_done  = 1'b1;
        nn_class = CLASS_W'(cls);
        tick();
        nn_done  = 1'b0;
        exp_class = cls;
        exp_valid = 1;
        total++;
        if (class_out !== CLASS_W'(exp_class) || class_valid !== 1'b1 || busy !== 1'b0 || error !== 1'b0)
            begin bad++; $display("FAIL %s result: got class=%0d valid=%b busy=%b err=%b want %0d/1/0/0", tag, class_out, class_valid, busy, error, exp_class); end
        d = vec_diff();
        total++;
        if (d >= 0)
            begin bad++; $display("FAIL %s snapshot_hold: elem %0d got %0d want %0d", tag, d, $signed(nn_vec[d*FEAT_W +: FEAT_W]), exp_vec[d]); end
        $display("cycle %s: fv_delay=%0d nd_delay=%0d class=%0d", tag, fv_delay, nd_delay, cls);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < N_FEAT; i++) exp_vec[i] = 0;
        exp_class = 0;
        exp_valid = 0;
        total++;
        if (feat_start !== 1'b0 || nn_start !== 1'b0 || class_out !== '0 || class_valid !== 1'b0 ||
            busy !== 1'b0 || error !== 1'b0 || nn_vec !== '0)
            begin bad++; $display("FAIL reset_state: got fs=%b ns=%b cls=%0d cv=%b busy=%b err=%b vec=%h want all 0",
                                  feat_start, nn_start, class_out, class_valid, busy, error, nn_vec); end
        rst = 1'b0;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_debounce();
        int starts = 0;
        int lat;
        for (int c = 0; c < 20; c++) begin
            but = ((c / 2) % 2 == 0);
            tick();
            if (feat_start) starts++;
        end
        but = 1'b0;
        repeat (8) begin
            tick();
            if (feat_start) starts++;
        end
        total++;
        if (starts != 0) begin bad++; $display("FAIL bounce: got %0d feat_start want 0", starts); end
        press_and_wait(lat);
        total++;
        if (lat != 7) begin bad++; $display("FAIL press_latency: got %0d want 7", lat); end
        starts = 0;
        repeat (3) begin
            tick();
            if (feat_start) starts++;
        end
        total++;
        if (starts != 0 || busy !== 1'b1) begin bad++; $display("FAIL single_start: got extra=%0d busy=%b want 0/1", starts, busy); end
        but = 1'b0;
        $display("debounce: latency=%0d extra_starts=%0d", lat, starts);
        finish_cycle(0, 0, 1, "deb_finish");
        release_but();
    endtask

    task automatic test_full_cycle();
        int lat;
        int d;
        press_and_wait(lat);
        total++;
        if (lat != 7) begin bad++; $display("FAIL full_latency: got %0d want 7", lat); end
        repeat (3) tick();
        random_stim();
        stim_vec[0]  = -5;
        stim_vec[25] = 17;
        drive_stim();
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        for (int i = 0; i < N_FEAT; i++) exp_vec[i] = stim_vec[i];
        d = vec_diff();
        total++;
        if (nn_start !== 1'b1 || d >= 0 || $signed(nn_vec[7:0]) != -5 || $signed(nn_vec[25*FEAT_W +: FEAT_W]) != 17)
            begin bad++; $display("FAIL full_snapshot: got start=%b e0=%0d e25=%0d diff=%0d want 1/-5/17/-1",
                                  nn_start, $signed(nn_vec[7:0]), $signed(nn_vec[25*FEAT_W +: FEAT_W]), d); end
        tick();
        tick();
        nn_done  = 1'b1;
        nn_class = 2'd2;
        tick();
        nn_done  = 1'b0;
        exp_class = 2;
        exp_valid = 1;
        total++;
        if (class_out !== 2'd2 || class_valid !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL full_result: got class=%0d valid=%b busy=%b want 2/1/0", class_out, class_valid, busy); end
        $display("full_cycle: e0=%0d e25=%0d class=%0d", $signed(nn_vec[7:0]), $signed(nn_vec[25*FEAT_W +: FEAT_W]), class_out);
        release_but();
    endtask

    task automatic test_ignored();
        int lat;
        int starts = 0;
        int not_busy = 0;
        int d;
        // spurious inputs in IDLE
        random_stim();
        drive_stim();
        feat_valid = 1'b1;
        nn_done    = 1'b1;
        nn_class   = CLASS_W'(exp_class + 1);
        tick();
        feat_valid = 1'b0;
        nn_done    = 1'b0;
        tick();
        d = vec_diff();
        total++;
        if (d >= 0 || class_out !== CLASS_W'(exp_class) || class_valid !== 1'(exp_valid) || busy !== 1'b0)
            begin bad++; $display("FAIL idle_ignore: got diff=%0d class=%0d valid=%b busy=%b want -1/%0d/%0d/0", d, class_out, class_valid, busy, exp_class, exp_valid); end
        // second press while waiting for inference
        press_and_wait(lat);
        random_stim();
        drive_stim();
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        for (int i = 0; i < N_FEAT; i++) exp_vec[i] = stim_vec[i];
        tick();
        but = 1'b0;
        repeat (8) begin tick(); if (feat_start) starts++; if (!busy) not_busy++; end
        but = 1'b1;
        repeat (12) begin tick(); if (feat_start) starts++; if (!busy) not_busy++; end
        total++;
        if (lat != 7 || starts != 0 || not_busy != 0)
            begin bad++; $display("FAIL busy_press: got lat=%0d starts=%0d idle_cycles=%0d want 7/0/0", lat, starts, not_busy); end
        nn_done  = 1'b1;
        nn_class = 2'd3;
        tick();
        nn_done  = 1'b0;
        exp_class = 3;
        exp_valid = 1;
        starts = 0;
        repeat (6) begin tick(); if (feat_start) starts++; end
        d = vec_diff();
        total++;
        if (class_out !== 2'd3 || class_valid !== 1'b1 || busy !== 1'b0 || starts != 0 || d >= 0)
            begin bad++; $display("FAIL busy_press_result: got class=%0d valid=%b busy=%b starts=%0d diff=%0d want 3/1/0/0/-1", class_out, class_valid, busy, starts, d); end
        $display("ignored: busy press starts=%0d class=%0d", starts, class_out);
        release_but();
    endtask

    task automatic test_random_cycles();
        int lat;
        for (int k = 0; k < 6; k++) begin
            press_and_wait(lat);
            total++;
            if (lat != 7) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want 7", k, lat); end
            but = 1'b0;
            finish_cycle(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
            release_but();
        end
    endtask

    task automatic test_watchdog();
        int lat;
        int early = 0;
`ifdef SSR_CTRL_WDOG_EN
        press_and_wait(lat);
        but = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            tick();
            if (busy !== 1'b1 || error !== 1'b0) early++;
        end
        tick();
        exp_valid = 0;
        total++;
        if (lat != 7 || early != 0 || error !== 1'b1 || busy !== 1'b0 || class_valid !== 1'b0 || class_out !== CLASS_W'(exp_class))
            begin bad++; $display("FAIL wdog_capture: got lat=%0d early=%0d err=%b busy=%b valid=%b class=%0d want 7/0/1/0/0/%0d",
                                  lat, early, error, busy, class_valid, class_out, exp_class); end
        release_but();
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL wdog_hold: got err=%b want 1", error); end
        press_and_wait(lat);
        but = 1'b0;
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL wdog_clear: got err=%b want 0", error); end
        random_stim();
        drive_stim();
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        for (int i = 0; i < N_FEAT; i++) exp_vec[i] = stim_vec[i];
        tick();
        repeat (TMO - 1) tick();
        nn_done  = 1'b1;
        nn_class = 2'd1;
        tick();
        nn_done  = 1'b0;
        exp_class = 1;
        exp_valid = 1;
        total++;
        if (class_valid !== 1'b1 || error !== 1'b0 || class_out !== 2'd1 || busy !== 1'b0)
            begin bad++; $display("FAIL wdog_tie: got valid=%b err=%b class=%0d busy=%b want 1/0/1/0", class_valid, error, class_out, busy); end
        $display("watchdog: timeout and tie checked");
        release_but();
`else
        press_and_wait(lat);
        but = 1'b0;
        repeat (3 * TMO) begin
            tick();
            if (busy !== 1'b1 || error !== 1'b0) early++;
        end
        total++;
        if (lat != 7 || early != 0)
            begin bad++; $display("FAIL no_wdog_wait: got lat=%0d aborted_cycles=%0d want 7/0", lat, early); end
        $display("watchdog: absent, waited %0d cycles", 3 * TMO);
        finish_cycle(0, TMO + 4, 0, "no_wdog");
        release_but();
`endif
    endtask

    task automatic test_reset_mid();
        int lat;
        press_and_wait(lat);
        but = 1'b0;
        random_stim();
        drive_stim();
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < N_FEAT; i++) exp_vec[i] = 0;
        exp_class = 0;
        exp_valid = 0;
        total++;
        if (feat_start !== 1'b0 || nn_start !== 1'b0 || class_out !== '0 || class_valid !== 1'b0 ||
            busy !== 1'b0 || error !== 1'b0 || nn_vec !== '0)
            begin bad++; $display("FAIL mid_reset: got fs=%b ns=%b cls=%0d cv=%b busy=%b err=%b vec=%h want all 0",
                                  feat_start, nn_start, class_out, class_valid, busy, error, nn_vec); end
        rst = 1'b0;
        nn_done  = 1'b1;
        nn_class = 2'd3;
        tick();
        nn_done  = 1'b0;
        tick();
        total++;
        if (class_valid !== 1'b0 || class_out !== '0 || busy !== 1'b0 || feat_start !== 1'b0)
            begin bad++; $display("FAIL post_reset_done: got cv=%b cls=%0d busy=%b fs=%b want 0/0/0/0", class_valid, class_out, busy, feat_start); end
        $display("reset_mid: lat=%0d outputs cleared", lat);
    endtask

    initial begin
        rst        = 1'b1;
        but        = 1'b0;
        feat_valid = 1'b0;
        nn_done    = 1'b0;
        nn_class   = '0;
        feat_vec   = '0;
        test_reset();
        test_debounce();
        test_full_cycle();
        test_ignored();
        test_random_cycles();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
